// File: rtl/pwm_pkg.sv
// Shared constants and helpers for the multi-channel ramped PWM.
// Build option: PWM_PHASE_STAGGER_EN staggers channel phases (see pwm_ramp_ctrl).
package pwm_pkg;

    localparam int DEF_NCH    = 2;
    localparam int DEF_DW     = 12;
    localparam int DEF_PERIOD = 4095;
    localparam int DEF_STEP   = 64;

    // Counter width able to hold 0..period.
    function automatic int cnt_width(input int period);
        return (period < 1) ? 1 : $clog2(period + 1);
    endfunction

    // Move cur toward eff by at most step, landing exactly on eff when close.
    // Operands are duty-sized (well under 31 bits) so the 32-bit math cannot wrap.
    function automatic logic [31:0] step_toward(
        input logic [31:0] cur,
        input logic [31:0] eff,
        input logic [31:0] step
    );
        logic [31:0] diff;
        logic [31:0] nxt;
        if (eff >= cur) begin
            diff = eff - cur;
            nxt  = (diff <= step) ? eff : cur + step;
        end else begin
            diff = cur - eff;
            nxt  = (diff <= step) ? eff : cur - step;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/pwm_ramp_channel.sv
// One PWM channel: slew-limited duty register, comparator and pulse flop.
// PHASE rotates the compare count; the top sets it under PWM_PHASE_STAGGER_EN.
module pwm_ramp_channel
    import pwm_pkg::*;
#(
    parameter int DW        = DEF_DW,
    parameter int PERIOD    = DEF_PERIOD,
    parameter int STEP      = DEF_STEP,
    parameter int HARD_STOP = 0,
    parameter int PHASE     = 0,
    parameter int CW        = cnt_width(DEF_PERIOD)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [CW-1:0] cnt_d,
    input  logic          tick,
    input  logic          estop,
    input  logic [DW-1:0] eff,
    output logic [DW-1:0] duty,
    output logic [DW-1:0] duty_nxt,
    output logic          pulse
);

    localparam logic [31:0] PH_W   = 32'(PHASE);
    localparam logic [31:0] PMOD_W = 32'(PERIOD + 1);
    localparam logic [31:0] STEP_W = 32'(STEP);
    localparam bit          HS     = (HARD_STOP != 0);

    logic [DW-1:0] duty_q;
    logic [DW-1:0] duty_d;
    logic          pulse_q;
    logic          pulse_d;
    logic [31:0]   ph_sum;
    logic [31:0]   ph_cnt;

    // Duty moves only at the wrap, except a hard stop which zeroes it at once.
    always_comb begin
        duty_d = duty_q;
        if (HS && estop) begin
            duty_d = '0;
        end else if (tick) begin
            duty_d = DW'(step_toward(32'(duty_q), 32'(eff), STEP_W));
        end
    end

    // Pulse is computed from next-cycle count and duty so it lines up with them.
    always_comb begin
        ph_sum  = 32'(cnt_d) + PH_W;
        ph_cnt  = (ph_sum >= PMOD_W) ? ph_sum - PMOD_W : ph_sum;
        pulse_d = (ph_cnt < 32'(duty_d));
    end

    // Duty and pulse state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            duty_q  <= '0;
            pulse_q <= 1'b0;
        end else begin
            duty_q  <= duty_d;
            pulse_q <= pulse_d;
        end
    end

    assign duty     = duty_q;
    assign duty_nxt = duty_d;
    assign pulse    = pulse_q;

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// Multi-channel PWM with soft start/stop, period-boundary updates and estop.
// Build option: define PWM_PHASE_STAGGER_EN to stagger channel rising edges.
module pwm_ramp_ctrl
    import pwm_pkg::*;
#(
    parameter int NCH       = DEF_NCH,
    parameter int DW        = DEF_DW,
    parameter int PERIOD    = DEF_PERIOD,
    parameter int STEP      = DEF_STEP,
    parameter int HARD_STOP = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NCH*DW-1:0] target,
    input  logic              load,
    input  logic              estop,
    output logic [NCH-1:0]    pulse,
    output logic [NCH*DW-1:0] duty_now,
    output logic              ramping,
    output logic              period_tick
);

    localparam int            CW       = cnt_width(PERIOD);
    localparam logic [CW-1:0] CNT_LAST = CW'(PERIOD);

    logic [CW-1:0]     cnt_q;
    logic [CW-1:0]     cnt_d;
    logic [NCH*DW-1:0] stg_q;
    logic [NCH*DW-1:0] stg_d;
    logic [NCH*DW-1:0] eff_all;
    logic [NCH*DW-1:0] nxt_all;
    logic              ramp_q;
    logic              ramp_d;
    logic              tick;

    assign tick        = (cnt_q == CNT_LAST);
    assign period_tick = tick;

    // Free-running period counter 0..PERIOD.
    always_comb begin
        cnt_d = tick ? '0 : cnt_q + CW'(1);
    end

    // Staging holds the last loaded target; estop masks it to zero.
    always_comb begin
        stg_d   = load ? target : stg_q;
        eff_all = estop ? '0 : stg_q;
    end

    // Any channel not yet at its effective target counts as ramping.
    always_comb begin
        ramp_d = (nxt_all != eff_all);
    end

    // Shared counter, staging and ramping state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q  <= '0;
            stg_q  <= '0;
            ramp_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            stg_q  <= stg_d;
            ramp_q <= ramp_d;
        end
    end

    assign ramping = ramp_q;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
`ifdef PWM_PHASE_STAGGER_EN
        localparam int PH = i * ((PERIOD + 1) / NCH);
`else
        localparam int PH = 0;
`endif
        pwm_ramp_channel #(
            .DW        (DW),
            .PERIOD    (PERIOD),
            .STEP      (STEP),
            .HARD_STOP (HARD_STOP),
            .PHASE     (PH),
            .CW        (CW)
        ) u_ch (
            .clk      (clk),
            .reset    (reset),
            .cnt_d    (cnt_d),
            .tick     (tick),
            .estop    (estop),
            .eff      (eff_all[i*DW +: DW]),
            .duty     (duty_now[i*DW +: DW]),
            .duty_nxt (nxt_all[i*DW +: DW]),
            .pulse    (pulse[i])
        );
    end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Testbench for pwm_ramp_ctrl: soft-stop and hard-stop instances vs a model.
// Honours PWM_PHASE_STAGGER_EN in its reference model.
module tb_pwm_ramp_ctrl;

    localparam int NCH = 2;
    localparam int DW  = 8;
    localparam int PER = 9;
    localparam int STP = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic [NCH*DW-1:0] target;
    logic              load;
    logic              estop;

    logic [NCH-1:0]    pulse_s, pulse_h;
    logic [NCH*DW-1:0] duty_s, duty_h;
    logic              ramp_s, ramp_h, tick_s, tick_h;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [1:0]  ps;
        logic [15:0] ds;
        logic        rs;
        logic        tk;
        logic [1:0]  ph;
        logic [15:0] dh;
        logic        rh;
    } exp_t;

    exp_t q[$];
    int   m_cnt;
    int   ms_duty[NCH];
    int   mh_duty[NCH];
    int   m_stage[NCH];

    always #5 clk = ~clk;

    pwm_ramp_ctrl #(.NCH(NCH), .DW(DW), .PERIOD(PER), .STEP(STP), .HARD_STOP(0)) dut (
        .clk(clk), .reset(reset), .target(target), .load(load), .estop(estop),
        .pulse(pulse_s), .duty_now(duty_s), .ramping(ramp_s), .period_tick(tick_s)
    );

    pwm_ramp_ctrl #(.NCH(NCH), .DW(DW), .PERIOD(PER), .STEP(STP), .HARD_STOP(1)) dut_hs (
        .clk(clk), .reset(reset), .target(target), .load(load), .estop(estop),
        .pulse(pulse_h), .duty_now(duty_h), .ramping(ramp_h), .period_tick(tick_h)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    function automatic int approach(input int cur, input int eff);
        int d;
        d = eff - cur;
        if (d < 0) d = -d;
        if (d <= STP) return eff;
        return (eff > cur) ? cur + STP : cur - STP;
    endfunction

    function automatic int phase_of(input int cnt, input int ch);
`ifdef PWM_PHASE_STAGGER_EN
        return (cnt + ch * ((PER + 1) / NCH)) % (PER + 1);
`else
        return cnt + 0 * ch;
`endif
    endfunction

    // Reference model: one step per clock, pushes the expected post-edge outputs.
    always @(posedge clk or negedge reset) begin : mdl
        int   eff[NCH];
        bit   wrap;
        exp_t e;
        if (!reset) begin
            m_cnt = 0;
            for (int i = 0; i < NCH; i++) begin
                ms_duty[i] = 0;
                mh_duty[i] = 0;
                m_stage[i] = 0;
            end
            q.delete();
        end else begin
            wrap = (m_cnt == PER);
            e    = '0;
            for (int i = 0; i < NCH; i++) begin
                eff[i] = estop ? 0 : m_stage[i];
                if (wrap) ms_duty[i] = approach(ms_duty[i], eff[i]);
                if (estop) mh_duty[i] = 0;
                else if (wrap) mh_duty[i] = approach(mh_duty[i], eff[i]);
                if (ms_duty[i] != eff[i]) e.rs = 1'b1;
                if (mh_duty[i] != eff[i]) e.rh = 1'b1;
                if (load) m_stage[i] = int'(target[i*DW +: DW]);
            end
            m_cnt = wrap ? 0 : m_cnt + 1;
            e.tk  = (m_cnt == PER);
            for (int i = 0; i < NCH; i++) begin
                e.ps[i]         = (phase_of(m_cnt, i) < ms_duty[i]);
                e.ph[i]         = (phase_of(m_cnt, i) < mh_duty[i]);
                e.ds[i*DW +: DW] = ms_duty[i][DW-1:0];
                e.dh[i*DW +: DW] = mh_duty[i][DW-1:0];
            end
            q.push_back(e);
        end
    end

    // Monitor: compares every cycle's outputs with the queued expectation.
    always @(posedge clk) begin : mon
        exp_t e;
        #1;
        if (reset && q.size() > 0) begin
            e = q.pop_front();
            chk("soft outputs", {12'd0, pulse_s, duty_s, ramp_s, tick_s},
                {12'd0, e.ps, e.ds, e.rs, e.tk});
            chk("hard outputs", {12'd0, pulse_h, duty_h, ramp_h, tick_h},
                {12'd0, e.ph, e.dh, e.rh, e.tk});
        end
    end

    task automatic wait_cnt(input int v);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (m_cnt != v && n < 40);
        if (m_cnt != v) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_cnt: actual=%0d expected=%0d", m_cnt, v);
        end
    endtask

    task automatic wait_wrap();
        wait_cnt(0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        int c0, c1;
        reset  = 1'b0;
        load   = 1'b0;
        estop  = 1'b0;
        target = '0;
        repeat (3) @(negedge clk);
        chk("rst soft", {12'd0, pulse_s, duty_s, ramp_s, tick_s}, 32'd0);
        chk("rst hard", {12'd0, pulse_h, duty_h, ramp_h, tick_h}, 32'd0);

        // Soft start to {5,10}
        @(negedge clk);
        reset  = 1'b1;
        target = {8'd10, 8'd5};
        load   = 1'b1;
        @(negedge clk);
        load = 1'b0;
        wait_wrap();
        chk("s1 w1 ch0", 32'(duty_s[7:0]), 32'd3);
        chk("s1 w1 ch1", 32'(duty_s[15:8]), 32'd3);
        wait_wrap();
        chk("s1 w2 ch0", 32'(duty_s[7:0]), 32'd5);
        chk("s1 w2 ch1", 32'(duty_s[15:8]), 32'd6);
        wait_wrap();
        chk("s1 w3 ch1", 32'(duty_s[15:8]), 32'd9);
        chk("s1 w3 ramping", 32'(ramp_s), 32'd1);
        wait_wrap();
        chk("s1 w4 ch1", 32'(duty_s[15:8]), 32'd10);
        chk("s1 w4 ramping", 32'(ramp_s), 32'd0);
        c1 = 0;
        for (int k = 0; k < 10; k++) begin
            if (pulse_s[1]) c1++;
            @(negedge clk);
        end
        chk("s1 ch1 full high", 32'(c1), 32'd10);

        // Mid-period load does not disturb the running period
        target = {8'd10, 8'd6};
        load   = 1'b1;
        @(negedge clk);
        load = 1'b0;
        wait_wrap();
        chk("s2 ch0 six", 32'(duty_s[7:0]), 32'd6);
        c0 = 0;
        for (int k = 0; k < 10; k++) begin
            if (m_cnt == 4) begin
                target = {8'd10, 8'd2};
                load   = 1'b1;
            end else begin
                load = 1'b0;
            end
            if (pulse_s[0]) c0++;
            @(negedge clk);
        end
        load = 1'b0;
        chk("s2 high count", 32'(c0), 32'd6);
        chk("s2 next duty", 32'(duty_s[7:0]), 32'd3);
        wait_wrap();
        chk("s2 final duty", 32'(duty_s[7:0]), 32'd2);

        // Estop: soft ramps down, hard drops at once
        target = {8'd10, 8'd9};
        load   = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (3) wait_wrap();
        chk("s3 ch0 nine", 32'(duty_s[7:0]), 32'd9);
        wait_cnt(2);
        estop = 1'b1;
        @(negedge clk);
        chk("s4 hard duty", 32'(duty_h), 32'd0);
        chk("s4 hard pulse", 32'(pulse_h), 32'd0);
        chk("s4 soft held", 32'(duty_s[7:0]), 32'd9);
        wait_wrap();
        chk("s3 down 6", 32'(duty_s[7:0]), 32'd6);
        wait_wrap();
        chk("s3 down 3", 32'(duty_s[7:0]), 32'd3);
        wait_wrap();
        chk("s3 down 0", 32'(duty_s[7:0]), 32'd0);
        estop = 1'b0;
        wait_wrap();
        chk("s3 up 3", 32'(duty_s[7:0]), 32'd3);
        chk("s4 hard up 3", 32'(duty_h[7:0]), 32'd3);
        wait_wrap();
        chk("s3 up 6", 32'(duty_s[7:0]), 32'd6);
        wait_wrap();
        chk("s3 up 9", 32'(duty_s[7:0]), 32'd9);

        // Asynchronous reset mid-pulse
        wait_cnt(5);
        chk("s5 pre pulse", 32'(pulse_s[0]), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("s5 async pulse", 32'(pulse_s), 32'd0);
        chk("s5 async duty", 32'(duty_s), 32'd0);
        chk("s5 async cnt", 32'(dut.cnt_q), 32'd0);
        chk("s5 async hard", {15'd0, pulse_h, duty_h}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        c0 = 0;
        for (int k = 0; k < 10; k++) begin
            if (pulse_s != 0 || pulse_h != 0) c0++;
            @(negedge clk);
        end
        chk("s5 quiet period", 32'(c0), 32'd0);

        // Randomized loads and estop episodes
        for (int k = 0; k < 400; k++) begin
            load = ($urandom_range(0, 5) == 0);
            if (load) target = 16'($urandom);
            if ($urandom_range(0, 39) == 0) estop = ~estop;
            @(negedge clk);
        end
        load  = 1'b0;
        estop = 1'b0;
        repeat (20) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pwm_ramp_ctrl.md
Name: pwm_ramp_ctrl

Overview:
Multi-channel PWM generator for the motor drive path that replaces the fixed single-channel PWM.
- Per-channel target duty is slew-limited (soft start/stop) and applied only at period boundaries, so outputs never glitch.
- An emergency-stop input, driven by distance/flag logic, forces all channels to zero either immediately or by ramping down.
- Sits between the flag/switch logic and the H-bridge EN pins.

Parameters:
- NCH, 2, number of PWM channels.
- DW, 12, duty width in bits.
- PERIOD, 4095, counter terminal value; PWM period = PERIOD+1 clk cycles.
- STEP, 64, maximum duty change per period while ramping.
- HARD_STOP, 0, 1 = estop zeroes duty immediately; 0 = estop ramps down at STEP.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- target  in  NCH*DW  packed per-channel target duty; channel i is bits [i*DW +: DW].
- load  in  1  single-cycle strobe; samples target into the staging register.
- estop  in  1  level; while 1, effective target for all channels is 0.
- pulse  out  NCH  PWM outputs.
- duty_now  out  NCH*DW  current applied duty per channel.
- ramping  out  1  1 while any channel's applied duty differs from its effective target.
- period_tick  out  1  one-cycle pulse on the last cycle of each period (cnt == PERIOD).

Behaviour:
- Reset (reset=0, async): cnt=0, staging=0, duty_now=0, pulse=0, ramping=0, period_tick=0.
- Counter: CW = $clog2(PERIOD+1) bits; counts 0..PERIOD, then wraps to 0. period_tick=1 when cnt==PERIOD.
- Load: on a cycle with load=1, staging <= target. Loads within one period overwrite each other; the last one wins. Applied duty never changes from a load mid-period.
- Effective target per channel: eff = estop ? 0 : staging[i].
- Update at wrap, i.e. the cycle with period_tick=1; the new duty is valid from cnt=0:
  - |eff - duty| <= STEP: duty <= eff.
  - eff > duty: duty <= duty + STEP.
  - Otherwise: duty <= duty - STEP.
  - Compute in DW+1 bits; no over/underflow past eff.
- HARD_STOP=1 and estop=1: duty_now <= 0 on the next clk, not waiting for wrap, and pulse drops on that same edge. After estop deasserts, ramp-up from 0 resumes at the next wrap.
- Output: pulse[i] registered, = (cnt < duty[i]).
  - duty=0 gives constant 0.
  - duty > PERIOD gives constant 1; duty values above PERIOD are legal and saturate to 100%.
- ramping: registered, = OR over channels of (duty != eff).
- Reset deassertion mid-operation: restart from cnt=0 with duty 0. No partial pulse is emitted.
- estop and load in the same cycle: staging still captures target; estop overrides eff while asserted.

Optional Feature:
- Macro PWM_PHASE_STAGGER_EN.
- Defined: channel i compares against a phase-offset count, (cnt + i*((PERIOD+1)/NCH)) mod (PERIOD+1), so rising edges are staggered and peak supply current drops. Duty update timing, still at global wrap, is unchanged.
- Undefined: all channels use cnt directly and rise together at cnt=0.

Decomposition:
- Shared package pwm_pkg:
  - clog2-based CW computation.
  - Default DW/PERIOD/STEP constants.
  - Saturating step-toward function (cur, eff, step) -> next.
- One sub-module, pwm_ramp_channel: per-channel duty register, step logic, comparator and pulse flop. The top holds the shared counter, staging register, estop logic and the ramping OR.

Test Plan:
All scenarios use NCH=2, DW=8, PERIOD=9, STEP=3.
- Reset release, target={5,10}, load once -> ch0 duty 3 then 5; ch1 duty 3, 6, 9, 10. ch1 pulse high 10/10 cycles once duty=10. ramping falls after the 4th wrap.
- Duty 6, load target 2 mid-period at cnt=4 -> current period still 6 high cycles; next period duty 3; following period 2.
- HARD_STOP=0, duty 9, estop=1 -> duties 6, 3, 0 at successive wraps. Release estop -> ramps back 3, 6, 9.
- HARD_STOP=1, duty 9, estop asserted at cnt=2 -> pulse 0 from the next edge, duty_now=0 immediately.
- Assert reset at cnt=5 while pulse=1 -> pulse, duty_now and cnt go to 0 asynchronously without waiting for clk. After release, first period pulse is 0.
- PWM_PHASE_STAGGER_EN defined, both duties 4 -> ch1 rising edge 5 cycles after ch0; each channel 4 high per 10 cycles.
